operand_fetch: RTL and testbench

// - Requester side of the 2-read/1-write register file: issues ra1/ra2, captures rd1/rd2 one cycle later.
// - Owns the write port: drives we1/wa/wd from writeback and forwards writeback data to in-flight operands.
// - Sits between decode and execute; two-stage pipeline (S1 read-wait, S2 operand-out).
// - Valid/ready on both sides; sustains 1 op/cycle.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/operand_fetch_if.sv | 52 +++++
 rtl/operand_bypass.sv | 47 ++++
 rtl/operand_fetch.sv | 113 +++++++++++
 tb/tb_operand_fetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared widths, types and the decode request record for the
// operand fetch slice.
//   DATA_W    register / operand width
//   ADDR_W    register address width
//   NUM_REGS  number of architectural registers
//   reg_addr_t, word_t, fetch_req_t {src1, src2, dst}
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    reg_addr_t src1;
    reg_addr_t src2;
    reg_addr_t dst;
  } fetch_req_t;

endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if -- bundles the decode, writeback, register-file and execute
// signals of the operand fetch unit.
//   master : operand_fetch view (drives dec_ready, rf_*, op_valid/op_a/op_b/op_dst)
//   slave  : environment view (decode, writeback, regfile, execute)
interface operand_fetch_if;
  import regfile_pkg::*;

  logic      dec_valid;
  logic      dec_ready;
  reg_addr_t dec_src1;
  reg_addr_t dec_src2;
  reg_addr_t dec_dst;

  logic      wb_valid;
  reg_addr_t wb_addr;
  word_t     wb_data;

  logic      rf_we1;
  reg_addr_t rf_wa;
  word_t     rf_wd;
  reg_addr_t rf_ra1;
  reg_addr_t rf_ra2;
  word_t     rf_rd1;
  word_t     rf_rd2;

  logic      op_valid;
  logic      op_ready;
  word_t     op_a;
  word_t     op_b;
  reg_addr_t op_dst;

  modport master (
    input  dec_valid, dec_src1, dec_src2, dec_dst,
    output dec_ready,
    input  wb_valid, wb_addr, wb_data,
    output rf_we1, rf_wa, rf_wd, rf_ra1, rf_ra2,
    input  rf_rd1, rf_rd2,
    output op_valid, op_a, op_b, op_dst,
    input  op_ready
  );

  modport slave (
    output dec_valid, dec_src1, dec_src2, dec_dst,
    input  dec_ready,
    output wb_valid, wb_addr, wb_data,
    input  rf_we1, rf_wa, rf_wd, rf_ra1, rf_ra2,
    output rf_rd1, rf_rd2,
    input  op_valid, op_a, op_b, op_dst,
    output op_ready
  );

endinterface

// File: rtl/operand_bypass.sv
// operand_bypass -- per-operand forwarding for the S1 stage.
//   clk, rst  clock, synchronous active-high reset (clears the forward flag)
//   rec_addr  address the regfile samples at this edge (rf_raN)
//   src       source register of the operand currently in S1
//   wb_*      writeback of the current cycle
//   rf_rd     registered regfile read data
//   opnd      forwarded operand
// Select priority: writeback this cycle, then writeback seen at the edge the
// regfile sampled src (its read returned the old value), then rf_rd.
// Optional macro OPERAND_FETCH_ZERO_REG_EN: register 0 always reads as zero.
module operand_bypass
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t rec_addr,
  input  reg_addr_t src,
  input  logic      wb_valid,
  input  reg_addr_t wb_addr,
  input  word_t     wb_data,
  input  word_t     rf_rd,
  output word_t     opnd
);

  logic  fwd_vld_p0;
  word_t fwd_data_p0;

  // previous-cycle write record, taken against whatever the regfile reads now
  always_ff @(posedge clk) begin
    if (rst) fwd_vld_p0 <= 1'b0;
    else     fwd_vld_p0 <= wb_valid && (wb_addr == rec_addr);
  end

  always_ff @(posedge clk) begin
    if (wb_valid && (wb_addr == rec_addr)) fwd_data_p0 <= wb_data;
  end

  always_comb begin
    opnd = rf_rd;
    if (wb_valid && (wb_addr == src)) opnd = wb_data;
    else if (fwd_vld_p0)              opnd = fwd_data_p0;
`ifdef OPERAND_FETCH_ZERO_REG_EN
    if (src == '0) opnd = '0;
`endif
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch -- requester side of a 2R/1W register file between decode
// and execute. Two stages: S1 waits for the registered read, S2 presents
// operands. Valid/ready on both sides, one op per cycle.
//   clk, rst  clock, synchronous active-high reset
//   bus       operand_fetch_if.master: decode request, writeback, regfile
//             ports (write port driven from writeback), operands to execute
// Optional macro OPERAND_FETCH_ZERO_REG_EN: register 0 is hardwired to zero
// and writes to it are suppressed.
module operand_fetch
  import regfile_pkg::*;
(
  input logic clk,
  input logic rst,
  operand_fetch_if.master bus
);

  logic       s1_vld_p1;
  fetch_req_t s1_req_p1;
  logic       vld_p2;
  fetch_req_t s2_req_p2;
  word_t      op_a_p2;
  word_t      op_b_p2;

  logic       s1_move;
  logic       s2_move;
  logic       accept;
  reg_addr_t  ra1;
  reg_addr_t  ra2;
  word_t      fwd_a;
  word_t      fwd_b;

  // Update of a held operand by a writeback to its source.
  function automatic word_t hold_upd(input word_t cur, input reg_addr_t src,
                                     input logic wv, input reg_addr_t wa,
                                     input word_t wd);
    word_t r;
    r = cur;
    if (wv && (wa == src)) r = wd;
`ifdef OPERAND_FETCH_ZERO_REG_EN
    if (src == '0) r = '0;
`endif
    return r;
  endfunction

  assign s2_move       = !vld_p2 || bus.op_ready;
  assign s1_move       = s1_vld_p1 && s2_move;
  assign bus.dec_ready = !s1_vld_p1 || s1_move;
  assign accept        = bus.dec_valid && bus.dec_ready;

  // A stalled S1 keeps re-reading its own sources so rf_rd stays current.
  assign ra1        = accept ? bus.dec_src1 : s1_req_p1.src1;
  assign ra2        = accept ? bus.dec_src2 : s1_req_p1.src2;
  assign bus.rf_ra1 = ra1;
  assign bus.rf_ra2 = ra2;

`ifdef OPERAND_FETCH_ZERO_REG_EN
  assign bus.rf_we1 = bus.wb_valid && (bus.wb_addr != '0);
`else
  assign bus.rf_we1 = bus.wb_valid;
`endif
  assign bus.rf_wa  = bus.wb_addr;
  assign bus.rf_wd  = bus.wb_data;

  operand_bypass u_byp_a (
    .clk(clk), .rst(rst), .rec_addr(ra1), .src(s1_req_p1.src1),
    .wb_valid(bus.wb_valid), .wb_addr(bus.wb_addr), .wb_data(bus.wb_data),
    .rf_rd(bus.rf_rd1), .opnd(fwd_a)
  );

  operand_bypass u_byp_b (
    .clk(clk), .rst(rst), .rec_addr(ra2), .src(s1_req_p1.src2),
    .wb_valid(bus.wb_valid), .wb_addr(bus.wb_addr), .wb_data(bus.wb_data),
    .rf_rd(bus.rf_rd2), .opnd(fwd_b)
  );

  // ---- S1: read wait ----
  always_ff @(posedge clk) begin
    if (rst)          s1_vld_p1 <= 1'b0;
    else if (accept)  s1_vld_p1 <= 1'b1;
    else if (s1_move) s1_vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) s1_req_p1 <= '{src1: bus.dec_src1, src2: bus.dec_src2, dst: bus.dec_dst};
  end

  // ---- S2: operand out ----
  always_ff @(posedge clk) begin
    if (rst)          vld_p2 <= 1'b0;
    else if (s2_move) vld_p2 <= s1_vld_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_req_p2 <= '0;
      op_a_p2   <= '0;
      op_b_p2   <= '0;
    end else if (s1_move) begin
      s2_req_p2 <= s1_req_p1;
      op_a_p2   <= fwd_a;
      op_b_p2   <= fwd_b;
    end else if (vld_p2 && !bus.op_ready) begin
      op_a_p2 <= hold_upd(op_a_p2, s2_req_p2.src1, bus.wb_valid, bus.wb_addr, bus.wb_data);
      op_b_p2 <= hold_upd(op_b_p2, s2_req_p2.src2, bus.wb_valid, bus.wb_addr, bus.wb_data);
    end
  end

  assign bus.op_valid = vld_p2;
  assign bus.op_a     = op_a_p2;
  assign bus.op_b     = op_b_p2;
  assign bus.op_dst   = s2_req_p2.dst;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch -- directed bench for operand_fetch with a behavioural
// register file, an architectural-state model and literal expectations.
// Honours OPERAND_FETCH_ZERO_REG_EN when defined for the whole build.
module tb_operand_fetch;
  import regfile_pkg::*;

`ifdef OPERAND_FETCH_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk;
  logic rst;
  operand_fetch_if bus();

  operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- register file: registered read, write-before-nothing
  word_t     mem [NUM_REGS];
  reg_addr_t ra1_s, ra2_s, wa_s;
  word_t     wd_s;
  logic      we_s, rst_s;

  always @(negedge clk) begin
    ra1_s <= bus.rf_ra1;
    ra2_s <= bus.rf_ra2;
    we_s  <= bus.rf_we1;
    wa_s  <= bus.rf_wa;
    wd_s  <= bus.rf_wd;
    rst_s <= rst;
  end

  always @(posedge clk) begin
    if (we_s) mem[wa_s] <= wd_s;
    if (!rst_s) begin
      bus.rf_rd1 <= mem[ra1_s];
      bus.rf_rd2 <= mem[ra2_s];
    end
  end

  // ---------------- model: operands equal architectural state at output time
  word_t      arch [NUM_REGS];
  fetch_req_t expq [$];

  function automatic word_t rdv(input reg_addr_t a);
    if (ZR && (a == '0)) return '0;
    return arch[a];
  endfunction

  always @(negedge clk) begin
    if (bus.op_valid) begin
      if (expq.size() == 0) chk("m_unexpected_op", 32'd1, 32'd0);
      else begin
        chk("m_op_a",   bus.op_a,   rdv(expq[0].src1));
        chk("m_op_b",   bus.op_b,   rdv(expq[0].src2));
        chk("m_op_dst", 32'(bus.op_dst), 32'(expq[0].dst));
      end
    end
    if (rst) expq.delete();
    else begin
      if (bus.op_valid && bus.op_ready && expq.size() > 0) void'(expq.pop_front());
      if (bus.dec_valid && bus.dec_ready)
        expq.push_back('{src1: bus.dec_src1, src2: bus.dec_src2, dst: bus.dec_dst});
    end
    if (bus.wb_valid && !(ZR && bus.wb_addr == '0)) arch[bus.wb_addr] <= bus.wb_data;
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int s1, input int s2, input int d);
    bus.dec_valid = 1'b1;
    bus.dec_src1  = reg_addr_t'(s1);
    bus.dec_src2  = reg_addr_t'(s2);
    bus.dec_dst   = reg_addr_t'(d);
  endtask

  task automatic wb(input int a, input int d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = reg_addr_t'(a);
    bus.wb_data  = word_t'(d);
  endtask

  task automatic chk_op(input string tag, input int a, input int b, input int d);
    chk({tag, "_valid"}, 32'(bus.op_valid), 32'd1);
    chk({tag, "_a"}, bus.op_a, a);
    chk({tag, "_b"}, bus.op_b, b);
    chk({tag, "_dst"}, 32'(bus.op_dst), d);
  endtask

  initial begin
    rst = 1'b1;
    bus.dec_valid = 1'b0; bus.dec_src1 = '0; bus.dec_src2 = '0; bus.dec_dst = '0;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.op_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_op_valid",  32'(bus.op_valid), 32'd0);
    chk("rst_dec_ready", 32'(bus.dec_ready), 32'd1);
    chk("rst_op_a",      bus.op_a, 32'd0);
    chk("rst_op_b",      bus.op_b, 32'd0);
    chk("rst_op_dst",    32'(bus.op_dst), 32'd0);
    step();

    // preload every register, then r1=5, r2=7
    for (int i = 0; i < NUM_REGS; i++) begin
      wb(i, 32'h1000 + i);
      step();
    end
    wb(1, 5); step();
    wb(2, 7); step();
    bus.wb_valid = 1'b0;
    step();

    // back-to-back
    req(1, 2, 3); step();
    req(2, 1, 4);
    @(negedge clk);
    chk("b2b_t1_op_valid", 32'(bus.op_valid), 32'd0);
    step();
    bus.dec_valid = 1'b0;
    @(negedge clk); chk_op("b2b_first", 5, 7, 3);
    step();
    @(negedge clk); chk_op("b2b_second", 7, 5, 4);
    step();
    @(negedge clk); chk("b2b_drain_valid", 32'(bus.op_valid), 32'd0);

    // same-cycle write at accept
    req(1, 2, 5); wb(1, 32'hAA);
    step();
    bus.dec_valid = 1'b0; bus.wb_valid = 1'b0;
    step();
    @(negedge clk); chk_op("samecyc", 32'hAA, 7, 5);
    step();

    // write in the cycle after accept
    req(1, 2, 6); step();
    bus.dec_valid = 1'b0; wb(2, 32'h55);
    step();
    bus.wb_valid = 1'b0;
    @(negedge clk); chk_op("prevcyc", 32'hAA, 32'h55, 6);
    step();

    // stall with S1 and S2 full
    bus.op_ready = 1'b0;
    req(1, 2, 7); step();
    req(2, 1, 8); step();
    req(3, 3, 9);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) wb(1, 9);
      @(negedge clk);
      chk("stall_dec_ready", 32'(bus.dec_ready), 32'd0);
      chk("stall_op_valid",  32'(bus.op_valid), 32'd1);
      chk("stall_op_dst",    32'(bus.op_dst), 32'd7);
      if (k >= 2) chk("stall_held_a", bus.op_a, 32'd9);
      step();
      bus.wb_valid = 1'b0;
    end
    bus.op_ready = 1'b1;
    wb(3, 32'h77);
    @(negedge clk);
    chk_op("stall_rel0", 9, 32'h55, 7);
    chk("stall_rel_dec_ready", 32'(bus.dec_ready), 32'd1);
    step();
    bus.wb_valid = 1'b0; bus.dec_valid = 1'b0;
    @(negedge clk); chk_op("stall_rel1", 32'h55, 9, 8);
    step();
    @(negedge clk); chk_op("stall_rel2_same_src", 32'h77, 32'h77, 9);
    step();
    @(negedge clk); chk("stall_drain_valid", 32'(bus.op_valid), 32'd0);

    // reset mid-stream
    req(1, 2, 10); step();
    req(2, 2, 11); step();
    bus.dec_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_op_valid",  32'(bus.op_valid), 32'd0);
    chk("midrst_dec_ready", 32'(bus.dec_ready), 32'd1);
    req(2, 1, 12); step();
    bus.dec_valid = 1'b0;
    @(negedge clk); chk("midrst_s1_only", 32'(bus.op_valid), 32'd0);
    step();
    @(negedge clk); chk_op("midrst_after", 32'h55, 9, 12);
    step();

    // register 0
    req(0, 1, 13); wb(0, 32'h33);
    @(negedge clk);
    chk("zero_we1", 32'(bus.rf_we1), ZR ? 32'd0 : 32'd1);
    step();
    bus.dec_valid = 1'b0; bus.wb_valid = 1'b0;
    step();
    @(negedge clk); chk_op("zero_reg", ZR ? 0 : 32'h33, 9, 13);
    step();
    step();

    @(negedge clk);
    chk("all_ops_delivered", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
